// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq -- sequenced signed multiply-accumulate.
//
// A start pulse in IDLE latches the product count (len), clears the
// accumulator and the overflow flag, and opens the operand port. Each accepted
// a/b pair goes through an operand register (_p0) and a product register (_p1)
// and is added into p two ce-cycles after acceptance. After the last pair the
// FSM spends two ce-cycles in DRAIN, so the final product has landed in p by
// the time HOLD presents the result. The consumer takes it with p_ready.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   ce             clock enable; 0 freezes every register
//   start, len     begin an accumulation of len products (sampled in IDLE)
//   in_valid/in_ready, a, b   operand handshake, signed N-bit operands
//   p, p_valid, p_ready       PW-bit result and its handshake
//   busy           FSM not in IDLE
//   ovf            sticky signed overflow of the current accumulation
module dsp_mac_seq #(
  parameter int N  = 18,
  parameter int PW = 48,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  output logic [PW-1:0] p,
  output logic          p_valid,
  input  logic          p_ready,
  output logic          busy,
  output logic          ovf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACC   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]             state;
  logic [LW-1:0]          len_q;
  logic [LW-1:0]          cnt;
  logic                   drn;

  logic signed [N-1:0]    a_p0;
  logic signed [N-1:0]    b_p0;
  logic                   vld_p0;
  logic signed [2*N-1:0]  prod_p1;
  logic                   vld_p1;
  logic signed [PW-1:0]   acc_p2;
  logic                   ovf_q;

  logic                   accept;
  logic signed [PW-1:0]   prod_ext;
  logic signed [PW-1:0]   sum;

  // Signed overflow of x + y: operands agree in sign, the sum does not.
  function automatic logic add_ovf(input logic signed [PW-1:0] x,
                                   input logic signed [PW-1:0] y,
                                   input logic signed [PW-1:0] s);
    return (x[PW-1] == y[PW-1]) && (s[PW-1] != x[PW-1]);
  endfunction

  assign in_ready = !rst && ce && (state == S_ACC) && (cnt < len_q);
  assign accept   = in_valid && in_ready;

  assign prod_ext = PW'(prod_p1);
  assign sum      = acc_p2 + prod_ext;

  assign p        = acc_p2;
  assign p_valid  = (state == S_HOLD);
  assign busy     = (state != S_IDLE);
  assign ovf      = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      len_q   <= '0;
      cnt     <= '0;
      drn     <= 1'b0;
      a_p0    <= '0;
      b_p0    <= '0;
      vld_p0  <= 1'b0;
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
      acc_p2  <= '0;
      ovf_q   <= 1'b0;
    end else if (ce) begin
      // Stage p0: operand register
      vld_p0 <= accept;
      if (accept) begin
        a_p0 <= a;
        b_p0 <= b;
      end
      // Stage p1: full-width signed product
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        prod_p1 <= (2*N)'(a_p0) * (2*N)'(b_p0);
      end
      // Stage p2: accumulate, wrapping modulo 2^PW
      if (vld_p1) begin
        acc_p2 <= sum;
        if (add_ovf(acc_p2, prod_ext, sum)) begin
          ovf_q <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          // The pipeline is empty here, so clearing p cannot lose a product.
          if (start) begin
            len_q  <= len;
            cnt    <= '0;
            acc_p2 <= '0;
            ovf_q  <= 1'b0;
            state  <= (len == '0) ? S_HOLD : S_ACC;
          end
        end
        S_ACC: begin
          if (accept) begin
            cnt <= cnt + LW'(1);
            if (cnt == len_q - LW'(1)) begin
              state <= S_DRAIN;
              drn   <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          // Two cycles: the last pair moves through p1 and into p.
          if (drn) begin
            state <= S_HOLD;
          end else begin
            drn <= 1'b1;
          end
        end
        default: begin
          if (p_ready) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Bench for dsp_mac_seq: two instances (PW=48 and PW=36) share all stimulus.
// Jobs come from a vector table; expected results are queued at start and
// popped when p_valid appears.
module tb_dsp_mac_seq;

  localparam int N  = 18;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst, ce, start, in_valid, p_ready;
  logic [LW-1:0] len;
  logic [N-1:0]  a, b;
  logic          in_ready, in_ready36;
  logic [47:0]   p48;
  logic [35:0]   p36;
  logic          p_valid, p_valid36, busy, busy36, ovf48, ovf36;

  dsp_mac_seq #(.N(N), .PW(48), .LW(LW)) u48 (
    .clk(clk), .rst(rst), .ce(ce), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .p(p48), .p_valid(p_valid), .p_ready(p_ready), .busy(busy), .ovf(ovf48));

  dsp_mac_seq #(.N(N), .PW(36), .LW(LW)) u36 (
    .clk(clk), .rst(rst), .ce(ce), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready36), .a(a), .b(b),
    .p(p36), .p_valid(p_valid36), .p_ready(p_ready), .busy(busy36), .ovf(ovf36));

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    int          av [8];
    int          bv [8];
    logic [15:0] vmask;   // in_valid per slot; 0 means always valid
    int          stall;   // slot at which ce drops for 3 cycles, -1 none
    bit          xstart;  // hold start high during ACC (must be ignored)
    longint      exp_p;
    bit          exp_ovf;
  } vec_t;

  typedef struct {
    longint p48;
    bit     o48;
    longint p36;
    bit     o36;
  } exp_t;

  vec_t vecs [7];
  exp_t sb [$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference accumulate at width w using exact 64-bit sums.
  function automatic void model(input int i, input int w,
                                output longint pv, output bit ov);
    longint s, wr;
    pv = 0;
    ov = 0;
    for (int k = 0; k < vecs[i].len; k++) begin
      s  = pv + longint'(vecs[i].av[k]) * longint'(vecs[i].bv[k]);
      wr = (s <<< (64 - w)) >>> (64 - w);
      if (wr != s) ov = 1;
      pv = wr;
    end
  endfunction

  task automatic run_job(input int i);
    exp_t e, g;
    int   k, j, cyc, lat;
    bit   acc;
    e.p48 = vecs[i].exp_p;
    e.o48 = vecs[i].exp_ovf;
    model(i, 36, e.p36, e.o36);
    sb.push_back(e);

    start = 1'b1;
    len   = LW'(vecs[i].len);
    step();
    start = vecs[i].xstart;
    len   = 8'd5;
    k = 0;
    j = 0;
    while (k < vecs[i].len && j < 32) begin
      if (j == vecs[i].stall) begin
        ce       = 1'b0;
        in_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
          #1;
          chk($sformatf("v%0d_stall_ready", i), longint'(in_ready), 0);
          step();
        end
        ce = 1'b1;
      end
      in_valid = (vecs[i].vmask == 0) ? 1'b1 : vecs[i].vmask[j];
      a = N'(vecs[i].av[k]);
      b = N'(vecs[i].bv[k]);
      #1;
      acc = in_valid && in_ready;
      step();
      if (acc) k++;
      j++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (k < vecs[i].len) chk($sformatf("v%0d_feed_timeout", i), k, vecs[i].len);

    if (vecs[i].len == 0)
      chk($sformatf("v%0d_ready_len0", i), longint'(in_ready), 0);
    cyc = 0;
    while (!p_valid && cyc < 20) begin
      step();
      cyc++;
    end
    lat = (vecs[i].len == 0) ? 0 : 2;
    chk($sformatf("v%0d_latency", i), cyc, lat);
    if (p_valid && sb.size() > 0) begin
      g = sb.pop_front();
      chk($sformatf("v%0d_p48", i), longint'($signed(p48)), g.p48);
      chk($sformatf("v%0d_ovf48", i), longint'(ovf48), longint'(g.o48));
      chk($sformatf("v%0d_p36", i), longint'($signed(p36)), g.p36);
      chk($sformatf("v%0d_ovf36", i), longint'(ovf36), longint'(g.o36));
      chk($sformatf("v%0d_valid36", i), longint'(p_valid36), 1);
    end
    // Stable in HOLD while p_ready is low.
    step();
    chk($sformatf("v%0d_hold_stable", i), longint'($signed(p48)), e.p48);
    // start with p_ready in HOLD: back to IDLE only.
    start   = 1'b1;
    p_ready = 1'b1;
    len     = 8'd3;
    step();
    start   = 1'b0;
    p_ready = 1'b0;
    chk($sformatf("v%0d_valid_clr", i), longint'(p_valid), 0);
    chk($sformatf("v%0d_idle", i), longint'(busy), 0);
    step();
    chk($sformatf("v%0d_start_ignored", i), longint'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3, '{2, -4, 7, 0, 0, 0, 0, 0}, '{3, 5, -1, 0, 0, 0, 0, 0},
                16'h0, 1, 1'b0, -21, 1'b0};
    vecs[1] = '{3, '{2, -4, 7, 0, 0, 0, 0, 0}, '{3, 5, -1, 0, 0, 0, 0, 0},
                16'h0, -1, 1'b0, -21, 1'b0};
    vecs[2] = '{2, '{131071, 1, 0, 0, 0, 0, 0, 0}, '{131071, 1, 0, 0, 0, 0, 0, 0},
                16'b1001, -1, 1'b1, 64'd17179607042, 1'b0};
    vecs[3] = '{0, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0},
                16'h0, -1, 1'b0, 0, 1'b0};
    vecs[4] = '{8, '{131071, 131071, 131071, 131071, 131071, 131071, 131071, 131071},
                '{131071, 131071, 131071, 131071, 131071, 131071, 131071, 131071},
                16'h0, -1, 1'b0, 64'd137436856328, 1'b0};
    vecs[5] = '{4, '{-131072, -131072, -131072, 0, 0, 0, 0, 0},
                '{-131072, -131072, 131071, 5, 0, 0, 0, 0},
                16'b10101101, -1, 1'b0, 64'd17180000256, 1'b0};
    vecs[6] = '{1, '{5, 0, 0, 0, 0, 0, 0, 0}, '{6, 0, 0, 0, 0, 0, 0, 0},
                16'h0, -1, 1'b0, 30, 1'b0};

    rst = 1'b1; ce = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    p_ready = 1'b0; a = '0; b = '0;
    step();
    chk("rst_in_ready", longint'(in_ready), 0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_p", longint'(p48), 0);
    chk("rst_p_valid", longint'(p_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_ovf", longint'(ovf48), 0);
    chk("rst_in_ready_idle", longint'(in_ready), 0);

    for (int i = 0; i < 6; i++) run_job(i);

    // rst pulsed in DRAIN, with ce low to show reset ignores ce.
    start = 1'b1;
    len   = 8'd2;
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    a = N'(100);
    b = N'(100);
    step();
    step();
    in_valid = 1'b0;
    chk("drain_busy", longint'(busy), 1);
    rst = 1'b1;
    ce  = 1'b0;
    step();
    rst = 1'b0;
    ce  = 1'b1;
    chk("drn_rst_p", longint'(p48), 0);
    chk("drn_rst_p_valid", longint'(p_valid), 0);
    chk("drn_rst_busy", longint'(busy), 0);
    chk("drn_rst_ovf", longint'(ovf48), 0);
    chk("drn_rst_in_ready", longint'(in_ready), 0);
    step();
    step();
    chk("drn_rst_flushed", longint'(p48), 0);
    run_job(6);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dsp_mac_seq.md
DSP_MAC_SEQ -- requirements
Module: dsp_mac_seq

Interface
REQ-001 Parameter N, default 18, operand width in bits (two's complement).
REQ-002 Parameter PW, default 48, accumulator and result width in bits.
REQ-003 Parameter LW, default 8, width of the product-count field.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 ce  input  1  clock enable; when 0 all internal registers hold their values.
REQ-007 start  input  1  begin an accumulation; sampled only in IDLE.
REQ-008 len  input  LW  number of products to accumulate; sampled with start.
REQ-009 in_valid  input  1  operand pair a/b is valid.
REQ-010 in_ready  output  1  block accepts an operand pair this cycle.
REQ-011 a, b  input  N each  signed operands.
REQ-012 p  output  PW  accumulated result, registered.
REQ-013 p_valid  output  1  p holds a final result.
REQ-014 p_ready  input  1  consumer takes p.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 ovf  output  1  sticky signed-overflow flag for the current accumulation.

Function
REQ-017 The FSM SHALL have states IDLE, ACC, DRAIN and HOLD.
REQ-018 In IDLE, a cycle with ce=1 and start=1 SHALL latch len, clear p, clear ovf and the accepted-operand count, and move to ACC, or to HOLD directly if len=0.
REQ-019 In ACC, in_ready SHALL equal ce AND (count < latched len); it SHALL be 0 in every other state.
REQ-020 The block SHALL accept an operand pair when in_valid=1 and in_ready=1, and SHALL increment count by 1 on each accepted pair.
REQ-021 The operand stage SHALL register each accepted pair, the multiply stage SHALL register the product one cycle later, and p SHALL include that product two ce-cycles after acceptance.
REQ-022 The product SHALL be the full 2N-bit signed product, sign-extended to PW; p SHALL update as p + product, wrapping modulo 2^PW.
REQ-023 ovf SHALL set when an addition overflows in signed PW-bit arithmetic, and SHALL stay set until the next start.
REQ-024 When the last pair is accepted, the FSM SHALL move to DRAIN, stay there exactly 2 ce-cycles, then move to HOLD.
REQ-025 In HOLD, p_valid SHALL be 1 and p SHALL be stable; p_ready=1 with ce=1 SHALL move the FSM to IDLE and clear p_valid on the next cycle.
REQ-026 start asserted outside IDLE SHALL be ignored, with no effect on len, p or count.
REQ-027 in_valid=0 in ACC SHALL insert bubbles: the FSM stays in ACC, count holds, and the pipeline advances zero products.
REQ-028 With ce=0, state, count, pipeline registers, p, ovf and p_valid SHALL hold, and in_ready SHALL be 0.
REQ-029 In HOLD, start=1 and p_ready=1 in the same cycle SHALL return the FSM to IDLE only; the start SHALL be ignored.

Reset
REQ-030 rst=1 at a clock edge SHALL, regardless of ce, force IDLE and set p=0, p_valid=0, ovf=0, busy=0, count=0 and all pipeline registers to 0.
REQ-031 rst=1 mid-accumulation SHALL discard all in-flight products; the first cycle after rst deasserts SHALL show IDLE with all outputs 0.
REQ-032 With rst=1, in_ready SHALL be 0.

Verification
REQ-033 start, len=3, then pairs (2,3), (-4,5), (7,-1) on consecutive cycles -> p=-21, p_valid=1 two cycles after DRAIN entry, ovf=0.
REQ-034 start, len=0 -> HOLD on the next cycle with p=0 and p_valid=1, and in_ready never asserted.
REQ-035 len=2 with in_valid toggling 1,0,0,1 and operands (131071,131071), (1,1) -> p=17179607042, and count stalls during the bubbles.
REQ-036 Preload by accumulating 8 products of (131071,131071) with PW overridden to 36 -> ovf=1 and p wrapped modulo 2^36.
REQ-037 ce=0 for 3 cycles mid-ACC, then ce=1 -> the result equals that of the same run without the stall, and in_ready=0 during the stall.
REQ-038 rst pulsed in DRAIN -> the next cycle shows IDLE, p=0, p_valid=0; a following start with len=1 and (5,6) -> p=30.
